// File: rtl/ir_decoder.sv
// NEC-style IR frame receiver: measures mark/space widths and rebuilds the 32-bit LSB-first frame.
// Optional: define IR_DECODER_INV_CHECK_EN to require data[31:24] == ~data[23:16] before committing.
module ir_decoder #(
  parameter int CLK_FREQ = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_input,
  output logic [31:0] data,
  output logic        valid,
  input  logic        ready,
  output logic        frame_err,
  output logic        overflow
);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, TRAIL
  } state_t;

  // Windows scale straight from CLK_FREQ so that sub-MHz clocks still resolve.
  function automatic logic [19:0] us_to_cyc(input longint us);
    return 20'(longint'(CLK_FREQ) * us / 64'sd1000000);
  endfunction

  function automatic logic in_win(input logic [19:0] v, input logic [19:0] lo,
                                  input logic [19:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  localparam logic [19:0] LEAD_MARK_MIN  = us_to_cyc(8000);
  localparam logic [19:0] LEAD_MARK_MAX  = us_to_cyc(10000);
  localparam logic [19:0] LEAD_SPACE_MIN = us_to_cyc(3500);
  localparam logic [19:0] LEAD_SPACE_MAX = us_to_cyc(5500);
  localparam logic [19:0] SHORT_MIN      = us_to_cyc(300);
  localparam logic [19:0] SHORT_MAX      = us_to_cyc(800);
  localparam logic [19:0] ONE_MIN        = us_to_cyc(1300);
  localparam logic [19:0] ONE_MAX        = us_to_cyc(2000);
  localparam logic [19:0] TIMEOUT        = us_to_cyc(11000);

  state_t      state, state_next;
  logic        sync1, sync2, sync3;
  logic        rise, fall;
  logic [19:0] cnt;
  logic [31:0] shift;
  logic [4:0]  idx;
  logic        err_now, bit_wr, bit_val, last_bit, check_ok;
  logic [31:0] frame_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= ir_input;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (rise || fall)
      cnt <= '0;
    else if (cnt != '1)
      cnt <= cnt + 20'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_now    = 1'b0;
    bit_wr     = 1'b0;
    bit_val    = 1'b0;
    last_bit   = 1'b0;
    if (state != IDLE && cnt > TIMEOUT) begin
      err_now = 1'b1;
    end else begin
      case (state)
        IDLE:       if (rise) state_next = LEAD_MARK;
        LEAD_MARK:  if (fall) begin
                      if (in_win(cnt, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_next = LEAD_SPACE;
                      else err_now = 1'b1;
                    end
        // Repeat codes have a short leader space; they fall out as errors here.
        LEAD_SPACE: if (rise) begin
                      if (in_win(cnt, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) state_next = BIT_MARK;
                      else err_now = 1'b1;
                    end else if (cnt > LEAD_SPACE_MAX) begin
                      err_now = 1'b1;
                    end
        BIT_MARK:   if (fall) begin
                      if (in_win(cnt, SHORT_MIN, SHORT_MAX)) state_next = BIT_SPACE;
                      else err_now = 1'b1;
                    end
        BIT_SPACE:  if (rise) begin
                      if (in_win(cnt, SHORT_MIN, SHORT_MAX)) begin
                        bit_wr = 1'b1;
                      end else if (in_win(cnt, ONE_MIN, ONE_MAX)) begin
                        bit_wr  = 1'b1;
                        bit_val = 1'b1;
                      end else begin
                        err_now = 1'b1;
                      end
                      if (bit_wr) begin
                        last_bit   = (idx == 5'd31);
                        state_next = last_bit ? TRAIL : BIT_MARK;
                      end
                    end
        TRAIL:      if (fall) state_next = IDLE;
        default:    state_next = IDLE;
      endcase
    end
    if (err_now) state_next = IDLE;
  end

  assign frame_word = {bit_val, shift[30:0]};

`ifdef IR_DECODER_INV_CHECK_EN
  assign check_ok = (frame_word[31:24] == ~frame_word[23:16]);
`else
  assign check_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift     <= '0;
      idx       <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= err_now | (last_bit & ~check_ok);
      overflow  <= last_bit & check_ok & valid;
      if (state == IDLE) begin
        shift <= '0;
        idx   <= '0;
      end else if (bit_wr) begin
        shift[idx] <= bit_val;
        idx        <= idx + 5'd1;
      end
      if (valid && ready)
        valid <= 1'b0;
      // A frame arriving while the previous one is still held is dropped.
      if (last_bit && check_ok && !valid) begin
        data  <= frame_word;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ir_decoder.sv
// Self-checking bench for ir_decoder: directed NEC scenarios plus randomized frames
// compared against a duration-level model of the receiver.
module tb_ir_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ir_input = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] data;
  logic        valid, frame_err, overflow;

  int total = 0;
  int bad = 0;
  int err_cnt = 0, ovf_cnt = 0, valid_cycles = 0;
  int err0, ovf0, vc0;
  logic [31:0] seen_data = '0;

  logic [31:0] exp_data = '0;
  logic        exp_valid = 1'b0;
  int          exp_err, exp_ovf;

  // A 50 kHz clock gives 20 us per cycle, keeping a whole frame to a few thousand cycles.
  ir_decoder #(.CLK_FREQ(50000)) dut (
    .clk(clk), .rst(rst), .ir_input(ir_input), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (valid === 1'b1) begin
        valid_cycles++;
        seen_data = data;
      end
      if (frame_err === 1'b1) err_cnt++;
      if (overflow === 1'b1) ovf_cnt++;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lv, input int us);
    ir_input = lv;
    repeat (us / 20) @(negedge clk);
  endtask

  function automatic int pick(input bit jitter, input int nominal, input int lo, input int hi);
    return jitter ? int'($urandom_range(hi, lo)) : nominal;
  endfunction

  // Sends one frame; bad_bit >= 0 corrupts that bit's space to 1.1 ms and aborts,
  // stop_bit >= 0 stops right after that bit's space with the line low.
  task automatic apply_stimulus(input logic [31:0] word, input bit jitter,
                                input int bad_bit, input int stop_bit);
    drive(1'b1, pick(jitter, 9000, 8400, 9600));
    drive(1'b0, pick(jitter, 4500, 3800, 5200));
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, pick(jitter, 560, 400, 700));
      if (i == bad_bit) begin
        drive(1'b0, 1100);
        drive(1'b1, 560);
        drive(1'b0, 2000);
        return;
      end
      if (word[i]) drive(1'b0, pick(jitter, 1680, 1400, 1900));
      else         drive(1'b0, pick(jitter, 560, 400, 700));
      if (i == stop_bit) return;
    end
    drive(1'b1, 560);
    drive(1'b0, 2000);
  endtask

  function automatic bit check_pass(input logic [31:0] word);
`ifdef IR_DECODER_INV_CHECK_EN
    return word[31:24] == ~word[23:16];
`else
    return 1'b1;
`endif
  endfunction

  // Receiver outcome for one frame, given whether its timing obeyed every window.
  task automatic predict(input logic [31:0] word, input bit timing_ok, input bit rdy);
    exp_err = 0;
    exp_ovf = 0;
    if (rdy) exp_valid = 1'b0;
    if (!timing_ok || !check_pass(word)) exp_err = 1;
    else if (exp_valid) exp_ovf = 1;
    else begin
      exp_data  = word;
      exp_valid = !rdy;
    end
  endtask

  task automatic snapshot();
    err0 = err_cnt;
    ovf0 = ovf_cnt;
    vc0  = valid_cycles;
  endtask

  task automatic check_frame(input string tag);
    check_output({tag, ".err"},   32'(err_cnt - err0), 32'(exp_err));
    check_output({tag, ".ovf"},   32'(ovf_cnt - ovf0), 32'(exp_ovf));
    check_output({tag, ".valid"}, {31'b0, valid}, {31'b0, exp_valid});
    check_output({tag, ".data"},  data, exp_data);
  endtask

  initial begin
    logic [31:0] word;
    bit          rdy;

    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset.data",      data, 32'h0);
    check_output("reset.valid",     {31'b0, valid}, 32'h0);
    check_output("reset.frame_err", {31'b0, frame_err}, 32'h0);
    check_output("reset.overflow",  {31'b0, overflow}, 32'h0);

    $display("[TB] nominal frame with ready high");
    ready = 1'b1;
    snapshot();
    predict(32'hFB040707, 1'b1, 1'b1);
    apply_stimulus(32'hFB040707, 1'b0, -1, -1);
    check_frame("nominal");
    check_output("nominal.vcycles", 32'(valid_cycles - vc0), 32'd1);
    check_output("nominal.seen",    seen_data, 32'hFB040707);

    $display("[TB] two frames held off by ready low");
    ready = 1'b0;
    snapshot();
    predict(32'hFB040707, 1'b1, 1'b0);
    apply_stimulus(32'hFB040707, 1'b0, -1, -1);
    check_frame("hold1");
    snapshot();
    predict(32'h12ED0707, 1'b1, 1'b0);
    apply_stimulus(32'h12ED0707, 1'b0, -1, -1);
    check_frame("hold2");
    ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("release.valid", {31'b0, valid}, 32'h0);
    exp_valid = 1'b0;

    $display("[TB] short leader mark");
    @(negedge clk);
    snapshot();
    exp_err = 1;
    exp_ovf = 0;
    drive(1'b1, 5000);
    drive(1'b0, 2000);
    check_frame("short_leader");
    snapshot();
    predict(32'hFB040707, 1'b1, 1'b1);
    apply_stimulus(32'hFB040707, 1'b0, -1, -1);
    check_frame("after_leader");
    check_output("after_leader.seen", seen_data, 32'hFB040707);

    $display("[TB] ambiguous bit-7 space");
    snapshot();
    predict(32'hFB040707, 1'b0, 1'b1);
    apply_stimulus(32'hFB040707, 1'b0, 7, -1);
    check_frame("bad_space");
    check_output("bad_space.vcycles", 32'(valid_cycles - vc0), 32'd0);

    $display("[TB] frame failing the inverse check");
    ready = 1'b0;
    snapshot();
    predict(32'h00040707, 1'b1, 1'b0);
    apply_stimulus(32'h00040707, 1'b0, -1, -1);
    check_frame("inv_check");

    $display("[TB] reset in the middle of a frame");
    snapshot();
    apply_stimulus(32'hFB040707, 1'b0, -1, 10);
    rst = 1'b0;
    ir_input = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_err   = 0;
    exp_ovf   = 0;
    check_frame("mid_reset");
    ready = 1'b1;
    snapshot();
    predict(32'hFB040707, 1'b1, 1'b1);
    apply_stimulus(32'hFB040707, 1'b0, -1, -1);
    check_frame("post_reset");
    check_output("post_reset.seen", seen_data, 32'hFB040707);

    $display("[TB] randomized frames");
    for (int n = 0; n < 4; n++) begin
      word = $urandom;
      if ($urandom_range(1, 0) == 1) word[31:24] = ~word[23:16];
      rdy   = 1'($urandom_range(1, 0));
      ready = rdy;
      snapshot();
      predict(word, 1'b1, rdy);
      apply_stimulus(word, 1'b1, -1, -1);
      check_frame($sformatf("random%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
